sd_cmd_engine: RTL and testbench

- SPI-mode SD command engine. It serialises one 48-bit command frame onto DI at one bit per clk, then hunts for the card's response on DO and captures R1 plus 0..RESP_EXTRA_MAX extra bytes (R3/R7).
- It replaces the fixed-CRC command sender: CRC7 is computed for any index/argument, and it adds response capture, an Ncr timeout, chip-select control and a trailing-clock phase.
- Sits between the SD init/read controllers and the SPI pins; clk is the SPI bit clock domain.

---
 rtl/sd_pkg.sv | 43 ++++
 rtl/crc7_serial.sv | 45 ++++
 rtl/sd_cmd_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: definitions shared by the SPI-mode SD command engine.
// Contents: FSM state enum, command frame constants, common command indices,
// the CRC7 polynomial, and small helper functions used by the engine and CRC.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RX,
    ST_TRAIL,
    ST_DONE
  } sd_state_e;

  // Command frame layout: {start, transmit, index[5:0], argument[31:0], crc7, end}
  localparam int   FRAME_BITS     = 48;
  // CRC7 covers the first 40 frame bits (start bit through argument LSB)
  localparam int   CRC_COVER_BITS = FRAME_BITS - 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic TX_BIT         = 1'b1;
  localparam logic END_BIT        = 1'b1;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One serial CRC7 step, message bit entering at the top.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// crc7_serial: bit-serial CRC7 (x^7+x^3+1, initial value 0).
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   clear_i    - restart the CRC from zero
//   enable_i   - absorb bit_i this cycle; when clear_i is also high the bit is
//                absorbed into a fresh (zero) CRC so the first message bit
//                needs no separate clear cycle
//   bit_i      - message bit
//   crc_o      - current CRC value
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] crc_base;

  always_comb begin
    crc_base = clear_i ? 7'h00 : crc_q;
    crc_d    = crc_q;
    if (enable_i) begin
      crc_d = crc7_step(crc_base, bit_i);
    end else if (clear_i) begin
      crc_d = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SPI-mode SD command engine.
// Sends one 48-bit command frame (CRC7 generated on the fly) on DI, one bit per
// clk, then hunts DO for the R1 start (first 0), captures R1 plus resp_len extra
// bytes, deasserts chip select for TRAIL_BITS cycles and pulses done.
// Ports:
//   clk, rst          - bit clock, synchronous active-high reset
//   start             - request, accepted only in IDLE
//   index, argument   - command index and argument
//   resp_len          - extra response bytes (clamped to RESP_EXTRA_MAX)
//   DO                - card data out (MISO)
//   DI, cs_n          - card data in (MOSI), chip select (active low)
//   busy, done        - transaction in progress, one-cycle completion pulse
//   timeout           - no response within NCR_BYTES bytes (valid with done)
//   resp_r1, resp_data- R1 byte and right-aligned extra bytes
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int RESP_EXTRA_MAX = 4,
  parameter int NCR_BYTES      = 8,
  parameter int TRAIL_BITS     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [5:0]                    index,
  input  logic [31:0]                   argument,
  input  logic [2:0]                    resp_len,
  input  logic                          DO,
  output logic                          DI,
  output logic                          cs_n,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [7:0]                    resp_r1,
  output logic [8*RESP_EXTRA_MAX-1:0]   resp_data
);

  localparam int DATA_W     = 8 * RESP_EXTRA_MAX;
  localparam int RX_BITS    = 8 + DATA_W;
  localparam int NCR_CYCLES = NCR_BYTES * 8;
  localparam int CNT_MAX    = max_int(max_int(FRAME_BITS, NCR_CYCLES),
                                      max_int(RX_BITS, TRAIL_BITS));
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  sd_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [39:0]         tx_q, tx_d;
  logic [2:0]          len_q, len_d;
  // Holds everything but the last received bit; the final shift is taken
  // combinationally straight into the result registers.
  logic [RX_BITS-2:0]  rx_q, rx_d;
  logic                di_q, di_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          r1_q, r1_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                crc_clr, crc_en, crc_bit;
  logic [6:0]          crc_val;

  logic [39:0]         frame_hi;
  logic [2:0]          len_clamped;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    rx_total;
  logic [RX_BITS-1:0]  rx_shift;
  logic [DATA_W-1:0]   data_mask;

  assign frame_hi    = {START_BIT, TX_BIT, index, argument};
  assign len_clamped = (resp_len > 3'(RESP_EXTRA_MAX)) ? 3'(RESP_EXTRA_MAX) : resp_len;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign rx_total    = CNT_W'(8) + CNT_W'({len_q, 3'b000});
  assign rx_shift    = {rx_q, DO};

  // Keep only the requested number of extra bytes; the rest read as zero.
  for (genvar gi = 0; gi < RESP_EXTRA_MAX; gi++) begin : g_mask
    assign data_mask[8*gi +: 8] = (3'(gi) < len_q) ? 8'hFF : 8'h00;
  end

  crc7_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (crc_clr),
    .enable_i (crc_en),
    .bit_i    (crc_bit),
    .crc_o    (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    len_d     = len_q;
    rx_d      = rx_q;
    di_d      = di_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    r1_d      = r1_q;
    data_d    = data_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = tx_q[39];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          cnt_d     = CNT_W'(1);
          // Frame bit 47 goes out immediately and is folded into a fresh CRC.
          di_d      = frame_hi[39];
          tx_d      = {frame_hi[38:0], 1'b0};
          len_d     = len_clamped;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          r1_d      = 8'hFF;
          data_d    = '0;
          crc_clr   = 1'b1;
          crc_en    = 1'b1;
          crc_bit   = frame_hi[39];
        end
      end

      // cnt_q = number of frame bits already on the wire.
      ST_SEND: begin
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          di_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_W'(CRC_COVER_BITS)) begin
            // CRC has absorbed bit 8 on the previous edge; reload the shifter
            // with the remaining CRC bits followed by the end bit.
            di_d = crc_val[6];
            tx_d = {crc_val[5:0], END_BIT, {33{1'b1}}};
          end else begin
            di_d = tx_q[39];
            tx_d = {tx_q[38:0], 1'b1};
            if (cnt_q < CNT_W'(CRC_COVER_BITS)) begin
              crc_en = 1'b1;
            end
          end
        end
      end

      ST_WAIT: begin
        if (!DO) begin
          // This zero is R1 bit 7.
          state_d = ST_RX;
          rx_d    = '0;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(NCR_CYCLES - 1)) begin
          state_d   = ST_TRAIL;
          timeout_d = 1'b1;
          cs_n_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RX: begin
        rx_d  = rx_shift[RX_BITS-2:0];
        cnt_d = cnt_inc;
        if (cnt_inc == rx_total) begin
          r1_d    = rx_shift[{len_q, 3'b000} +: 8];
          data_d  = rx_shift[DATA_W-1:0] & data_mask;
          state_d = ST_TRAIL;
          cs_n_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_TRAIL: begin
        if (cnt_q == CNT_W'(TRAIL_BITS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      len_q     <= '0;
      rx_q      <= '0;
      di_q      <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      r1_q      <= 8'hFF;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      len_q     <= len_d;
      rx_q      <= rx_d;
      di_q      <= di_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      r1_q      <= r1_d;
      data_q    <= data_d;
    end
  end

  assign DI        = di_q;
  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign resp_r1   = r1_q;
  assign resp_data = data_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed self-checking bench for sd_cmd_engine.
// Cycle n is the clock period following accept edge n-1; the card model drives
// DO for cycle n right after edge n-1, with stream bit k landing in cycle 49+k.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, DO;
  logic [5:0]  index;
  logic [31:0] argument;
  logic [2:0]  resp_len;
  logic        DI, cs_n, busy, done, timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] frame_cap;
  logic        di_hist   [0:255];
  logic        cs_hist   [0:255];
  logic        busy_hist [0:255];
  int          done_cnt, done_cyc;
  logic [7:0]  r1_at;
  logic [31:0] data_at;
  logic        to_at;

  sd_cmd_engine #(.RESP_EXTRA_MAX(4), .NCR_BYTES(8), .TRAIL_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .index(index), .argument(argument),
    .resp_len(resp_len), .DO(DO), .DI(DI), .cs_n(cs_n), .busy(busy),
    .done(done), .timeout(timeout), .resp_r1(resp_r1), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Runs one command and records per-cycle outputs. Extra start pulses are
  // driven in cycles pulse_a/pulse_b, reset in cycle rst_cyc (-1 = none).
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [2:0] len, input logic [127:0] bits,
                         input int nbits, input int pulse_a, input int pulse_b,
                         input int rst_cyc, input int max_cyc);
    int k;
    frame_cap = '0; done_cnt = 0; done_cyc = -1;
    r1_at = 8'h00; data_at = '0; to_at = 1'b0;
    for (int i = 0; i < 256; i++) begin
      di_hist[i] = 1'b0; cs_hist[i] = 1'b0; busy_hist[i] = 1'b0;
    end
    @(negedge clk);
    index = idx; argument = arg; resp_len = len; DO = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; index = ~idx; argument = ~arg; resp_len = 3'd0;
    for (int c = 1; c <= max_cyc; c++) begin
      k = c - 49;
      DO    = (k >= 0 && k < nbits) ? bits[127-k] : 1'b1;
      start = (c == pulse_a) || (c == pulse_b);
      rst   = (c == rst_cyc);
      di_hist[c] = DI; cs_hist[c] = cs_n; busy_hist[c] = busy;
      if (c <= 48) frame_cap[48-c] = DI;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; r1_at = resp_r1; data_at = resp_data; to_at = timeout;
        end
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0; DO = 1'b1;
    $display("txn cmd=%0d arg=%h len=%0d frame=%h done_cycle=%0d dones=%0d r1=%h data=%h timeout=%0b",
             idx, arg, len, frame_cap, done_cyc, done_cnt, r1_at, data_at, to_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; DO = 1'b1; index = '0; argument = '0; resp_len = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (DI !== 1'b1)       begin n_fail++; $display("FAIL reset_di: got %b expected 1", DI); end
    n_checks++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (timeout !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_checks++; if (resp_r1 !== 8'hFF) begin n_fail++; $display("FAIL reset_r1: got %h expected ff", resp_r1); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", resp_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cmd0();
    // FF FF 01: R1 start at cycle 65, done at 65+16 = 81
    run_txn(CMD0, 32'h0, 3'd0, {24'hFFFF01, 104'd0}, 24, -1, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h400000000095) begin n_fail++; $display("FAIL cmd0_frame: got %h expected 400000000095", frame_cap); end
    n_checks++; if (r1_at !== 8'h01)  begin n_fail++; $display("FAIL cmd0_r1: got %h expected 01", r1_at); end
    n_checks++; if (to_at !== 1'b0)   begin n_fail++; $display("FAIL cmd0_timeout: got %b expected 0", to_at); end
    n_checks++; if (done_cnt !== 1)   begin n_fail++; $display("FAIL cmd0_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (done_cyc !== 81)  begin n_fail++; $display("FAIL cmd0_done_cycle: got %0d expected 81", done_cyc); end
    n_checks++; if (busy_hist[1] !== 1'b1 || cs_hist[1] !== 1'b0)
      begin n_fail++; $display("FAIL cmd0_cycle1: got busy=%b cs_n=%b expected busy=1 cs_n=0", busy_hist[1], cs_hist[1]); end
    n_checks++; if (cs_hist[72] !== 1'b0 || cs_hist[73] !== 1'b1)
      begin n_fail++; $display("FAIL cmd0_trail_edge: got cs_n72=%b cs_n73=%b expected 0 1", cs_hist[72], cs_hist[73]); end
  endtask

  task automatic test_cmd8();
    // 01 00 00 01 AA starting at cycle 49: done at 49+16+32 = 97
    run_txn(CMD8, 32'h000001AA, 3'd4, {40'h01000001AA, 88'd0}, 40, -1, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h48000001AA87) begin n_fail++; $display("FAIL cmd8_frame: got %h expected 48000001aa87", frame_cap); end
    n_checks++; if (r1_at !== 8'h01)  begin n_fail++; $display("FAIL cmd8_r1: got %h expected 01", r1_at); end
    n_checks++; if (data_at !== 32'h000001AA) begin n_fail++; $display("FAIL cmd8_data: got %h expected 000001aa", data_at); end
    n_checks++; if (done_cyc !== 97)  begin n_fail++; $display("FAIL cmd8_done_cycle: got %0d expected 97", done_cyc); end
    // resp_len 7 clamps to 4
    run_txn(CMD8, 32'h000001AA, 3'd7, {40'h01000001AA, 88'd0}, 40, -1, -1, -1, 200);
    n_checks++; if (data_at !== 32'h000001AA || done_cyc !== 97)
      begin n_fail++; $display("FAIL cmd8_clamp: got data=%h cycle=%0d expected 000001aa 97", data_at, done_cyc); end
    // resp_len 2: right-aligned, upper bytes zero, done at 49+16+16 = 81
    run_txn(CMD8, 32'h000001AA, 3'd2, {24'h01ABCD, 104'd0}, 24, -1, -1, -1, 200);
    n_checks++; if (data_at !== 32'h0000ABCD) begin n_fail++; $display("FAIL len2_data: got %h expected 0000abcd", data_at); end
    n_checks++; if (r1_at !== 8'h01 || done_cyc !== 81)
      begin n_fail++; $display("FAIL len2_r1_cycle: got r1=%h cycle=%0d expected 01 81", r1_at, done_cyc); end
  endtask

  task automatic test_back_to_back();
    // FF 01: done at 57+16 = 73; a start in the done cycle must be ignored
    run_txn(CMD55, 32'h0, 3'd0, {16'hFF01, 112'd0}, 16, 73, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h770000000065) begin n_fail++; $display("FAIL cmd55_frame: got %h expected 770000000065", frame_cap); end
    n_checks++; if (done_cyc !== 73 || r1_at !== 8'h01)
      begin n_fail++; $display("FAIL cmd55_done: got cycle=%0d r1=%h expected 73 01", done_cyc, r1_at); end
    n_checks++; if (busy_hist[74] !== 1'b0) begin n_fail++; $display("FAIL start_in_done: got busy=%b expected 0", busy_hist[74]); end
    // Started in the cycle right after done; FF FF 00 gives done at 81
    run_txn(ACMD41, 32'h40000000, 3'd0, {24'hFFFF00, 104'd0}, 24, -1, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h694000000077) begin n_fail++; $display("FAIL acmd41_frame: got %h expected 694000000077", frame_cap); end
    n_checks++; if (busy_hist[1] !== 1'b1) begin n_fail++; $display("FAIL acmd41_accept: got busy=%b expected 1", busy_hist[1]); end
    n_checks++; if (done_cyc !== 81 || r1_at !== 8'h00)
      begin n_fail++; $display("FAIL acmd41_done: got cycle=%0d r1=%h expected 81 00", done_cyc, r1_at); end
  endtask

  task automatic test_timeout();
    run_txn(CMD0, 32'h0, 3'd0, 128'd0, 0, -1, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h400000000095) begin n_fail++; $display("FAIL to_frame: got %h expected 400000000095", frame_cap); end
    n_checks++; if (di_hist[49] !== 1'b1) begin n_fail++; $display("FAIL to_wait_di: got %b expected 1", di_hist[49]); end
    n_checks++; if (cs_hist[112] !== 1'b0 || cs_hist[113] !== 1'b1 || cs_hist[120] !== 1'b1)
      begin n_fail++; $display("FAIL to_cs_n: got c112=%b c113=%b c120=%b expected 0 1 1", cs_hist[112], cs_hist[113], cs_hist[120]); end
    n_checks++; if (done_cyc !== 121 || done_cnt !== 1)
      begin n_fail++; $display("FAIL to_done: got cycle=%0d count=%0d expected 121 1", done_cyc, done_cnt); end
    n_checks++; if (to_at !== 1'b1 || r1_at !== 8'hFF)
      begin n_fail++; $display("FAIL to_flags: got timeout=%b r1=%h expected 1 ff", to_at, r1_at); end
  endtask

  task automatic test_ignore_start();
    // Pulses in SEND (cycle 10) and WAIT (cycle 52); FF 05 -> done at 73
    run_txn(CMD0, 32'h0, 3'd0, {16'hFF05, 112'd0}, 16, 10, 52, -1, 200);
    n_checks++; if (frame_cap !== 48'h400000000095) begin n_fail++; $display("FAIL ign_frame: got %h expected 400000000095", frame_cap); end
    n_checks++; if (done_cnt !== 1 || done_cyc !== 73)
      begin n_fail++; $display("FAIL ign_done: got count=%0d cycle=%0d expected 1 73", done_cnt, done_cyc); end
    n_checks++; if (r1_at !== 8'h05) begin n_fail++; $display("FAIL ign_r1: got %h expected 05", r1_at); end
  endtask

  task automatic test_reset_mid();
    run_txn(CMD8, 32'h000001AA, 3'd4, {40'h01000001AA, 88'd0}, 40, -1, -1, 20, 140);
    n_checks++; if (busy_hist[20] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy20: got %b expected 1", busy_hist[20]); end
    n_checks++; if (di_hist[21] !== 1'b1 || cs_hist[21] !== 1'b1 || busy_hist[21] !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_outputs: got di=%b cs_n=%b busy=%b expected 1 1 0", di_hist[21], cs_hist[21], busy_hist[21]); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    run_txn(CMD0, 32'h0, 3'd0, {24'hFFFF01, 104'd0}, 24, -1, -1, -1, 200);
    n_checks++; if (frame_cap !== 48'h400000000095 || r1_at !== 8'h01 || done_cyc !== 81)
      begin n_fail++; $display("FAIL rstmid_recover: got frame=%h r1=%h cycle=%0d expected 400000000095 01 81", frame_cap, r1_at, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_back_to_back();
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
